// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares one system-bus slave port between N masters.
// Port 0 (VGA scan-out) gets bounded priority; ports 1..N-1 are served round-robin.
module sysbus_arbiter #(
  parameter int N        = 4,
  parameter int AW       = 24,
  parameter int DW       = 16,
  parameter int HOLD_MAX = 8,
  parameter int TIMEOUT  = 64,
  localparam int IW      = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [N-1:0]    m_req,
  input  logic [N-1:0]    m_we,
  input  logic [N*AW-1:0] m_addr,
  input  logic [N*DW-1:0] m_wdata,
  output logic [N-1:0]    m_ack,
  output logic [DW-1:0]   m_rdata,
  output logic            m_err,
  output logic            s_req,
  output logic            s_we,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  input  logic            s_ack,
  input  logic [DW-1:0]   s_rdata,
  output logic [IW-1:0]   grant_id,
  output logic            busy
);

  localparam int SW = $clog2(HOLD_MAX + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]    r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [SW-1:0] r_streak;
  logic [TW-1:0] r_tcnt;

  logic          w_any;
  logic          w_others;
  logic          w_p0_win;
  logic          w_rr_found;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_rr_win;
  logic [IW-1:0] w_win;
  logic          w_done;

  assign w_any    = |m_req;
  assign w_others = |m_req[N-1:1];
  assign w_p0_win = m_req[0] && ((r_streak < SW'(HOLD_MAX)) || !w_others);
  assign w_win    = w_p0_win ? '0 : w_rr_win;
  assign w_done   = s_ack || (r_tcnt == TW'(TIMEOUT - 1));

  // Round-robin search over ports 1..N-1, starting just after the last winner.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_win   = '0;
    w_idx      = '0;
    for (int i = 1; i < N; i++) begin
      w_idx = IW'(((int'(r_rr_ptr) - 1 + i) % (N - 1)) + 1);
      if (!w_rr_found && m_req[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= IW'(N - 1);
      r_streak <= '0;
      r_tcnt   <= '0;
      m_ack    <= '0;
      m_rdata  <= '0;
      m_err    <= 1'b0;
      s_req    <= 1'b0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      m_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (!m_req[0]) r_streak <= '0;
          if (w_any) begin
            r_state  <= S_GRANT;
            s_req    <= 1'b1;
            busy     <= 1'b1;
            s_we     <= m_we[w_win];
            s_addr   <= m_addr[int'(w_win)*AW +: AW];
            s_wdata  <= m_wdata[int'(w_win)*DW +: DW];
            grant_id <= w_win;
            if (w_win == '0) begin
              if (r_streak != SW'(HOLD_MAX)) r_streak <= r_streak + 1'b1;
            end else begin
              r_streak <= '0;
              r_rr_ptr <= w_win;
            end
          end
        end
        S_GRANT: begin
          // A slave ack on the deadline cycle still counts as a normal completion.
          if (w_done) begin
            r_state <= S_RESP;
            s_req   <= 1'b0;
            r_tcnt  <= '0;
            m_ack   <= N'(1) << grant_id;
            m_rdata <= s_ack ? s_rdata : '1;
            m_err   <= ~s_ack;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Self-checking bench for sysbus_arbiter: cycle table for basic transfers,
// hand-written sequences for round-robin, port-0 bound, timeout and reset.
module tb_sysbus_arbiter;
  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_ack;
  logic [DW-1:0]   m_rdata;
  logic            m_err;
  logic            s_req;
  logic            s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_ack;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      grant_id;
  logic            busy;

  int nChecks = 0;
  int nFail   = 0;

  sysbus_arbiter #(.N(N), .AW(AW), .DW(DW), .HOLD_MAX(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst_(rst_), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record k: inputs driven during cycle k, outputs expected in cycle k+1.
  typedef struct {
    logic [N-1:0]  req;
    logic          sAck;
    logic [DW-1:0] sRdata;
    logic          expSReq;
    logic          expBusy;
    logic [N-1:0]  expAck;
    logic [1:0]    expGid;
    logic [DW-1:0] expRdata;
    logic          expErr;
    logic [AW-1:0] expAddr;
    logic          expWe;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic ack, input logic [DW-1:0] rd);
    m_req   = req;
    s_ack   = ack;
    s_rdata = rd;
  endtask

  task automatic waitAck(input int limit, output logic [N-1:0] ack, output int cycles);
    ack    = '0;
    cycles = 0;
    while (cycles < limit && ack == '0) begin
      tick();
      cycles++;
      ack = m_ack;
    end
    if (ack == '0) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL ack_wait actual=none expected=ack within %0d cycles", limit);
    end
  endtask

  task automatic resetDut();
    applyStimulus('0, 1'b0, '0);
    rst_ = 1'b0;
    repeat (2) tick();
    rst_ = 1'b1;
    tick();
  endtask

  initial begin
    logic [N-1:0] ack;
    int           cyc;
    int           cnt;
    int           order[6];

    m_we    = 4'b0010;
    m_addr  = {24'h300003, 24'h000123, 24'h100001, 24'h000000};
    m_wdata = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    applyStimulus('0, 1'b0, '0);
    rst_ = 1'b0;

    vecs[0] = '{4'b0100, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000, 2'd2, 16'h0000, 1'b0, 24'h000123, 1'b0};
    vecs[1] = '{4'b0100, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000, 2'd2, 16'h0000, 1'b0, 24'h000123, 1'b0};
    vecs[2] = '{4'b0100, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000, 2'd2, 16'h0000, 1'b0, 24'h000123, 1'b0};
    vecs[3] = '{4'b0100, 1'b1, 16'hBEEF, 1'b0, 1'b1, 4'b0100, 2'd2, 16'hBEEF, 1'b0, 24'h000123, 1'b0};
    vecs[4] = '{4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000, 2'd2, 16'hBEEF, 1'b0, 24'h000123, 1'b0};
    vecs[5] = '{4'b0010, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000, 2'd1, 16'hBEEF, 1'b0, 24'h100001, 1'b1};
    vecs[6] = '{4'b0010, 1'b1, 16'h1234, 1'b0, 1'b1, 4'b0010, 2'd1, 16'h1234, 1'b0, 24'h100001, 1'b1};
    vecs[7] = '{4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000, 2'd1, 16'h1234, 1'b0, 24'h100001, 1'b1};
    vecs[8] = '{4'b0000, 1'b1, 16'hDEAD, 1'b0, 1'b0, 4'b0000, 2'd1, 16'h1234, 1'b0, 24'h100001, 1'b1};

    repeat (2) tick();
    checkOutput("reset s_req", 32'(s_req), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset m_ack", 32'(m_ack), 0);
    checkOutput("reset grant_id", 32'(grant_id), 0);
    checkOutput("reset m_rdata", 32'(m_rdata), 0);
    checkOutput("reset m_err", 32'(m_err), 0);
    rst_ = 1'b1;
    tick();

    for (int k = 0; k < 9; k++) begin
      applyStimulus(vecs[k].req, vecs[k].sAck, vecs[k].sRdata);
      tick();
      checkOutput($sformatf("vec%0d s_req", k), 32'(s_req), 32'(vecs[k].expSReq));
      checkOutput($sformatf("vec%0d busy", k), 32'(busy), 32'(vecs[k].expBusy));
      checkOutput($sformatf("vec%0d m_ack", k), 32'(m_ack), 32'(vecs[k].expAck));
      checkOutput($sformatf("vec%0d grant_id", k), 32'(grant_id), 32'(vecs[k].expGid));
      checkOutput($sformatf("vec%0d m_rdata", k), 32'(m_rdata), 32'(vecs[k].expRdata));
      checkOutput($sformatf("vec%0d m_err", k), 32'(m_err), 32'(vecs[k].expErr));
      checkOutput($sformatf("vec%0d s_addr", k), 32'(s_addr), 32'(vecs[k].expAddr));
      checkOutput($sformatf("vec%0d s_we", k), 32'(s_we), 32'(vecs[k].expWe));
    end

    // Round-robin among ports 1..3 with an immediately acking slave.
    resetDut();
    order = '{1, 2, 3, 1, 2, 3};
    applyStimulus(4'b1110, 1'b1, 16'h0042);
    for (int t = 0; t < 6; t++) begin
      waitAck(10, ack, cyc);
      checkOutput($sformatf("rr%0d m_ack", t), 32'(ack), 32'(1) << order[t]);
      checkOutput($sformatf("rr%0d spacing", t), 32'(cyc), (t == 0) ? 32'd2 : 32'd3);
    end
    applyStimulus('0, 1'b0, '0);
    repeat (2) tick();

    // Port 0 bounded priority, then port 0 alone.
    resetDut();
    applyStimulus(4'b0011, 1'b1, 16'h0007);
    for (int t = 0; t < 17; t++) begin
      waitAck(10, ack, cyc);
      checkOutput($sformatf("p0bound%0d m_ack", t), 32'(ack), (t == 8) ? 32'd2 : 32'd1);
    end
    m_req = 4'b0001;
    for (int t = 0; t < 10; t++) begin
      waitAck(10, ack, cyc);
      checkOutput($sformatf("p0alone%0d m_ack", t), 32'(ack), 32'd1);
    end
    applyStimulus('0, 1'b0, '0);
    repeat (2) tick();

    // Timeout on a port-1 write, then a normal read.
    applyStimulus(4'b0010, 1'b0, 16'h0000);
    tick();
    cnt = 0;
    while (s_req === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    checkOutput("timeout s_req cycles", 32'(cnt), 64);
    checkOutput("timeout m_ack", 32'(m_ack), 32'b0010);
    checkOutput("timeout m_err", 32'(m_err), 1);
    checkOutput("timeout m_rdata", 32'(m_rdata), 32'hFFFF);
    applyStimulus('0, 1'b0, '0);
    tick();
    applyStimulus(4'b0100, 1'b1, 16'h5A5A);
    waitAck(10, ack, cyc);
    checkOutput("after_timeout m_ack", 32'(ack), 32'b0100);
    checkOutput("after_timeout m_err", 32'(m_err), 0);
    checkOutput("after_timeout m_rdata", 32'(m_rdata), 32'h5A5A);
    applyStimulus('0, 1'b0, '0);
    repeat (2) tick();

    // Slave ack on the 64th GRANT cycle must complete normally.
    applyStimulus(4'b1000, 1'b0, 16'h0000);
    tick();
    for (int c = 1; c < 64; c++) tick();
    checkOutput("deadline s_req", 32'(s_req), 1);
    applyStimulus(4'b1000, 1'b1, 16'h1357);
    tick();
    checkOutput("deadline m_ack", 32'(m_ack), 32'b1000);
    checkOutput("deadline m_err", 32'(m_err), 0);
    checkOutput("deadline m_rdata", 32'(m_rdata), 32'h1357);
    applyStimulus('0, 1'b0, '0);
    repeat (2) tick();

    // Reset while port 1 is in GRANT; round-robin pointer must restart.
    applyStimulus(4'b0010, 1'b0, 16'h0000);
    repeat (2) tick();
    checkOutput("pre_reset s_req", 32'(s_req), 1);
    #3 rst_ = 1'b0;
    #1;
    checkOutput("async_reset s_req", 32'(s_req), 0);
    checkOutput("async_reset busy", 32'(busy), 0);
    checkOutput("async_reset m_ack", 32'(m_ack), 0);
    checkOutput("async_reset grant_id", 32'(grant_id), 0);
    applyStimulus(4'b1010, 1'b1, 16'h2468);
    #2 rst_ = 1'b1;
    waitAck(10, ack, cyc);
    checkOutput("post_reset m_ack", 32'(ack), 32'b0010);
    checkOutput("post_reset m_rdata", 32'(m_rdata), 32'h2468);
    applyStimulus('0, 1'b0, '0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
